// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, control bundle types and constants for the pipeline control unit
package ctrl_pkg;

  // RV32 base opcodes recognised by the decoder
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam int CTRL_W = 10;

  // ALU operation class handed to the ALU control stage
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_FUNCT  = 2'b10,
    ALUOP_PASS   = 2'b11
  } aluop_t;

  // Write-back source select
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

  // Control bundle; field order fixes the bit layout seen on the ports (alusrc is the MSB)
  typedef struct packed {
    logic    alusrc;
    aluop_t  aluop;
    logic    branch;
    logic    jump;
    logic    memread;
    logic    memwrite;
    wb_sel_t wb_sel;
    logic    regwrite;
  } ctrl_t;

  // A bubble does nothing in any stage: no memory access, no register write
  localparam ctrl_t CTRL_BUBBLE = '{
    alusrc:   1'b0,
    aluop:    ALUOP_ADD,
    branch:   1'b0,
    jump:     1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    wb_sel:   WB_ALU,
    regwrite: 1'b0
  };

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational opcode to control-bundle decoder
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int EN_JUMP = 1
) (
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       use_rs1,
  output logic       use_rs2,
  output logic       illegal
);

  // Map opcode to bundle and source usage; unknown opcodes decode to a bubble flagged illegal
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    use_rs1 = 1'b1;
    use_rs2 = 1'b0;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memread  = 1'b1;
        ctrl.wb_sel   = WB_MEM;
        ctrl.regwrite = 1'b1;
      end
      OP_STORE: begin
        ctrl.alusrc   = 1'b1;
        ctrl.memwrite = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_RTYPE: begin
        ctrl.aluop    = ALUOP_FUNCT;
        ctrl.regwrite = 1'b1;
        use_rs2       = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.aluop  = ALUOP_BRANCH;
        ctrl.branch = 1'b1;
        use_rs2     = 1'b1;
      end
      OP_IALU: begin
        ctrl.alusrc   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALUOP_PASS;
        ctrl.regwrite = 1'b1;
        use_rs1       = 1'b0;
      end
      OP_JAL, OP_JALR: begin
        if (EN_JUMP != 0) begin
          ctrl.alusrc   = 1'b1;
          ctrl.jump     = 1'b1;
          ctrl.wb_sel   = WB_PC4;
          ctrl.regwrite = 1'b1;
          // JAL has no register source; JALR reads rs1 for its target
          use_rs1       = (opcode == OP_JALR);
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// rtl/ctrl_pipe.sv - control-bundle pipeline with load-use hazard detection and event counters
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int CNT_W   = 16,
  parameter int EN_JUMP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_valid,
  input  logic              flush,
  input  logic              freeze,
  output logic              hazard_stall,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  ctrl_t             dec_ctrl;
  logic              dec_use_rs1;
  logic              dec_use_rs2;
  logic              dec_illegal;

  ctrl_t             ex_q;
  ctrl_t             mem_q;
  ctrl_t             wb_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic              ex_ill_q;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  flush_q;

  logic              load_in_ex;
  logic              rs1_hit;
  logic              rs2_hit;
  logic              kill_id;

  // Counter step that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  ctrl_decode #(
    .EN_JUMP (EN_JUMP)
  ) u_decode (
    .opcode  (id_opcode),
    .ctrl    (dec_ctrl),
    .use_rs1 (dec_use_rs1),
    .use_rs2 (dec_use_rs2),
    .illegal (dec_illegal)
  );

  // A load in EX whose result an ID source needs cannot forward in time; x0 never conflicts.
  // Flush kills the ID instruction anyway and freeze holds everything, so neither stalls.
  always_comb begin
    load_in_ex   = ex_q.memread && (ex_rd_q != '0);
    rs1_hit      = dec_use_rs1 && (ex_rd_q == id_rs1);
    rs2_hit      = dec_use_rs2 && (ex_rd_q == id_rs2);
    hazard_stall = id_valid && load_in_ex && (rs1_hit || rs2_hit) && !flush && !freeze;
    kill_id      = flush || hazard_stall || !id_valid;
  end

  // ID/EX register: bubble on kill, decoded bundle otherwise, hold on freeze
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= CTRL_BUBBLE;
      ex_rd_q  <= '0;
      ex_ill_q <= 1'b0;
    end else if (!freeze) begin
      if (kill_id) begin
        ex_q     <= CTRL_BUBBLE;
        ex_rd_q  <= '0;
        ex_ill_q <= 1'b0;
      end else begin
        ex_q     <= dec_ctrl;
        ex_rd_q  <= id_rd;
        ex_ill_q <= dec_illegal;
      end
    end
  end

  // EX/MEM and MEM/WB registers: plain shift, only freeze holds them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= CTRL_BUBBLE;
      mem_rd_q <= '0;
      wb_q     <= CTRL_BUBBLE;
      wb_rd_q  <= '0;
    end else if (!freeze) begin
      mem_q    <= ex_q;
      mem_rd_q <= ex_rd_q;
      wb_q     <= mem_q;
      wb_rd_q  <= mem_rd_q;
    end
  end

  // Event counters; hazard_stall already excludes frozen cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (hazard_stall) begin
        stall_q <= sat_inc(stall_q);
      end
      if (flush && !freeze) begin
        flush_q <= sat_inc(flush_q);
      end
    end
  end

  assign ex_ctrl    = ex_q;
  assign mem_ctrl   = mem_q;
  assign wb_ctrl    = wb_q;
  assign ex_rd      = ex_rd_q;
  assign mem_rd     = mem_rd_q;
  assign wb_rd      = wb_rd_q;
  assign ex_illegal = ex_ill_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb/tb_ctrl_pipe.sv - randomized self-checking bench for ctrl_pipe against a table-driven model
module tb_ctrl_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_valid, flush, freeze;

  logic        hazard_stall;
  logic [9:0]  ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_illegal;
  logic [15:0] stall_cnt, flush_cnt;

  logic        nj_hazard_stall;
  logic [9:0]  nj_ex_ctrl, nj_mem_ctrl, nj_wb_ctrl;
  logic [4:0]  nj_ex_rd, nj_mem_rd, nj_wb_rd;
  logic        nj_ex_illegal;
  logic [2:0]  nj_stall_cnt, nj_flush_cnt;

  int total = 0;
  int bad   = 0;

  // reference state: what each stage should hold
  logic [9:0]  m_ex, m_mem, m_wb;
  logic [4:0]  m_ex_rd, m_mem_rd, m_wb_rd;
  logic        m_ex_ill;
  int          m_stall, m_flush, m_flush_nj;

  localparam logic [9:0] B_LOAD = 10'b1000010011;
  localparam logic [9:0] B_RTYP = 10'b0100000001;
  localparam logic [9:0] B_JAL  = 10'b1000100101;

  ctrl_pipe #(.REG_AW(5), .CNT_W(16), .EN_JUMP(1)) dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_valid(id_valid), .flush(flush), .freeze(freeze),
    .hazard_stall(hazard_stall), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_illegal(ex_illegal),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  ctrl_pipe #(.REG_AW(5), .CNT_W(3), .EN_JUMP(0)) dut_nj (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_valid(id_valid), .flush(flush), .freeze(freeze),
    .hazard_stall(nj_hazard_stall), .ex_ctrl(nj_ex_ctrl), .mem_ctrl(nj_mem_ctrl),
    .wb_ctrl(nj_wb_ctrl), .ex_rd(nj_ex_rd), .mem_rd(nj_mem_rd), .wb_rd(nj_wb_rd),
    .ex_illegal(nj_ex_illegal), .stall_cnt(nj_stall_cnt), .flush_cnt(nj_flush_cnt)
  );

  // decode table: {illegal, use_rs1, use_rs2, bundle}
  function automatic logic [12:0] ref_dec(input logic [6:0] op, input bit en_jump);
    case (op)
      7'b0000011: return {3'b010, B_LOAD};
      7'b0100011: return {3'b011, 10'b1000001000};
      7'b0110011: return {3'b011, B_RTYP};
      7'b1100011: return {3'b011, 10'b0011000000};
      7'b0010011: return {3'b010, 10'b1000000001};
      7'b0110111: return {3'b000, 10'b1110000001};
      7'b0010111: return {3'b000, 10'b1110000001};
      7'b1101111: return en_jump ? {3'b000, B_JAL} : {3'b110, 10'b0};
      7'b1100111: return en_jump ? {3'b010, B_JAL} : {3'b110, 10'b0};
      default:    return {3'b110, 10'b0};
    endcase
  endfunction

  function automatic logic ref_hazard();
    logic [12:0] d;
    logic        dep;
    logic [9:0]  e;
    d   = ref_dec(id_opcode, 1'b1);
    e   = m_ex;
    dep = (d[11] && m_ex_rd == id_rs1) || (d[10] && m_ex_rd == id_rs2);
    return id_valid && e[4] && (m_ex_rd != 5'd0) && dep && !flush && !freeze;
  endfunction

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_ex_rd = '0; m_mem_rd = '0; m_wb_rd = '0; m_ex_ill = 1'b0;
    m_stall = 0; m_flush = 0; m_flush_nj = 0;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic v, input logic fl, input logic fr);
    id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_valid = v; flush = fl; freeze = fr;
  endtask

  // advance one clock, moving the model the way the pipeline is described to move
  task automatic tick();
    logic        hz;
    logic [12:0] d;
    hz = ref_hazard();
    d  = ref_dec(id_opcode, 1'b1);
    if (!freeze) begin
      if (hz && m_stall < 65535) m_stall++;
      if (flush && m_flush < 65535) m_flush++;
      if (flush && m_flush_nj < 7) m_flush_nj++;
      m_wb = m_mem; m_wb_rd = m_mem_rd;
      m_mem = m_ex; m_mem_rd = m_ex_rd;
      if (flush || hz || !id_valid) begin
        m_ex = '0; m_ex_rd = '0; m_ex_ill = 1'b0;
      end else begin
        m_ex = d[9:0]; m_ex_rd = id_rd; m_ex_ill = d[12];
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 30'd0) begin
      bad++; $display("FAIL reset_ctrl: got %h want 0", {ex_ctrl, mem_ctrl, wb_ctrl});
    end
    total++;
    if ({ex_rd, mem_rd, wb_rd, ex_illegal, hazard_stall} !== 17'd0) begin
      bad++; $display("FAIL reset_misc: got %h want 0", {ex_rd, mem_rd, wb_rd, ex_illegal, hazard_stall});
    end
    total++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_load_use();
    // lw x5 then add using x5: one stall cycle
    drive(7'b0000011, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    tick();
    drive(7'b0110011, 5'd5, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (hazard_stall !== 1'b1) begin
      bad++; $display("FAIL lu_stall: got %b want 1", hazard_stall);
    end
    tick();
    total++;
    if (ex_ctrl !== 10'd0 || ex_rd !== 5'd0 || hazard_stall !== 1'b0) begin
      bad++; $display("FAIL lu_bubble: got ctrl=%b rd=%0d hz=%b want 0/0/0", ex_ctrl, ex_rd, hazard_stall);
    end
    tick();
    total++;
    if (ex_ctrl !== B_RTYP || ex_rd !== 5'd9 || stall_cnt !== 16'd1) begin
      bad++; $display("FAIL lu_reenter: got ctrl=%b rd=%0d stall=%0d want %b/9/1", ex_ctrl, ex_rd, stall_cnt, B_RTYP);
    end
    // load to x0 never stalls
    drive(7'b0000011, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(7'b0110011, 5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    total++;
    if (hazard_stall !== 1'b0) begin
      bad++; $display("FAIL lu_x0: got %b want 0", hazard_stall);
    end
    tick();
    total++;
    if (ex_ctrl !== B_RTYP || stall_cnt !== 16'd1) begin
      bad++; $display("FAIL lu_x0_pass: got ctrl=%b stall=%0d want %b/1", ex_ctrl, stall_cnt, B_RTYP);
    end
  endtask

  task automatic test_rtype();
    drive(7'b0110011, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if (ex_ctrl[8:7] !== 2'b10 || ex_rd !== 5'd3) begin
      bad++; $display("FAIL rtype_ex: got aluop=%b rd=%0d want 10/3", ex_ctrl[8:7], ex_rd);
    end
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    total++;
    if (wb_ctrl[0] !== 1'b1 || wb_rd !== 5'd3 || wb_ctrl !== B_RTYP) begin
      bad++; $display("FAIL rtype_wb: got ctrl=%b rd=%0d want %b/3", wb_ctrl, wb_rd, B_RTYP);
    end
  endtask

  task automatic test_flush_hazard();
    logic [15:0] s0, f0;
    drive(7'b0000011, 5'd1, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    tick();
    s0 = stall_cnt; f0 = flush_cnt;
    drive(7'b0110011, 5'd6, 5'd6, 5'd7, 1'b1, 1'b1, 1'b0);
    #1;
    total++;
    if (hazard_stall !== 1'b0) begin
      bad++; $display("FAIL fh_stall: got %b want 0", hazard_stall);
    end
    tick();
    total++;
    if (ex_ctrl !== 10'd0 || flush_cnt !== f0 + 16'd1 || stall_cnt !== s0) begin
      bad++; $display("FAIL fh_result: got ctrl=%b flush=%0d stall=%0d want 0/%0d/%0d",
                      ex_ctrl, flush_cnt, stall_cnt, f0 + 16'd1, s0);
    end
    total++;
    if (mem_ctrl !== B_LOAD) begin
      bad++; $display("FAIL fh_mem_survives: got %b want %b", mem_ctrl, B_LOAD);
    end
  endtask

  task automatic test_freeze();
    logic [9:0]  ec, mc, wc;
    logic [15:0] sc, fc;
    drive(7'b1101111, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b0);
    tick();
    ec = ex_ctrl; mc = mem_ctrl; wc = wb_ctrl; sc = stall_cnt; fc = flush_cnt;
    total++;
    if (ec !== B_JAL) begin
      bad++; $display("FAIL frz_jal_ex: got %b want %b", ec, B_JAL);
    end
    for (int k = 0; k < 3; k++) begin
      drive(7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'($urandom), 1'b1);
      tick();
      total++;
      if (ex_ctrl !== ec || mem_ctrl !== mc || wb_ctrl !== wc || stall_cnt !== sc || flush_cnt !== fc) begin
        bad++; $display("FAIL frz_hold: cycle %0d got %h %h %h %0d %0d want %h %h %h %0d %0d",
                        k, ex_ctrl, mem_ctrl, wb_ctrl, stall_cnt, flush_cnt, ec, mc, wc, sc, fc);
      end
    end
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    total++;
    if (wb_ctrl[2:1] !== 2'b10 || wb_rd !== 5'd1) begin
      bad++; $display("FAIL frz_jal_wb: got wb_sel=%b rd=%0d want 10/1", wb_ctrl[2:1], wb_rd);
    end
  endtask

  task automatic test_illegal();
    drive(7'b1111111, 5'd1, 5'd1, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if (ex_illegal !== 1'b1 || ex_ctrl !== 10'd0) begin
      bad++; $display("FAIL ill_opcode: got ill=%b ctrl=%b want 1/0", ex_illegal, ex_ctrl);
    end
    drive(7'b1101111, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    total++;
    if (nj_ex_illegal !== 1'b1 || nj_ex_ctrl !== 10'd0) begin
      bad++; $display("FAIL ill_nojump: got ill=%b ctrl=%b want 1/0", nj_ex_illegal, nj_ex_ctrl);
    end
    total++;
    if (ex_illegal !== 1'b0 || ex_ctrl !== B_JAL) begin
      bad++; $display("FAIL ill_jump_ok: got ill=%b ctrl=%b want 0/%b", ex_illegal, ex_ctrl, B_JAL);
    end
  endtask

  task automatic test_random();
    logic [6:0] ops [10];
    logic       hz;
    int         errs;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011};
    errs = 0;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 9)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 7) == 0));
      #1;
      hz = ref_hazard();
      total++;
      if (hazard_stall !== hz) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_hazard: cycle %0d got %b want %b", i, hazard_stall, hz);
      end
      tick();
      total++;
      if (ex_ctrl !== m_ex || mem_ctrl !== m_mem || wb_ctrl !== m_wb ||
          ex_rd !== m_ex_rd || mem_rd !== m_mem_rd || wb_rd !== m_wb_rd || ex_illegal !== m_ex_ill) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_stages: cycle %0d got %h %h %h %0d %0d %0d %b want %h %h %h %0d %0d %0d %b",
                                i, ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, ex_illegal,
                                m_ex, m_mem, m_wb, m_ex_rd, m_mem_rd, m_wb_rd, m_ex_ill);
      end
      total++;
      if (int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush || int'(nj_flush_cnt) != m_flush_nj) begin
        bad++; errs++;
        if (errs < 10) $display("FAIL rnd_counters: cycle %0d got %0d %0d %0d want %0d %0d %0d",
                                i, stall_cnt, flush_cnt, nj_flush_cnt, m_stall, m_flush, m_flush_nj);
      end
    end
    total++;
    if (nj_flush_cnt !== 3'd7) begin
      bad++; $display("FAIL sat_flush: got %0d want 7", nj_flush_cnt);
    end
  endtask

  task automatic test_midstream_reset();
    drive(7'b0000011, 5'd1, 5'd0, 5'd2, 1'b1, 1'b0, 1'b0);
    tick();
    drive(7'b0110011, 5'd2, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if ({ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, ex_illegal, hazard_stall} !== 47'd0) begin
      bad++; $display("FAIL mid_reset_pipe: got %h want 0",
                      {ex_ctrl, mem_ctrl, wb_ctrl, ex_rd, mem_rd, wb_rd, ex_illegal, hazard_stall});
    end
    total++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || nj_flush_cnt !== 3'd0) begin
      bad++; $display("FAIL mid_reset_cnt: got %0d %0d %0d want 0 0 0", stall_cnt, flush_cnt, nj_flush_cnt);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    total++;
    if (ex_ctrl !== 10'd0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL mid_reset_after: got ctrl=%b stall=%0d want 0/0", ex_ctrl, stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_rtype();
    test_flush_hazard();
    test_freeze();
    test_illegal();
    test_random();
    test_midstream_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control unit for the 5-stage RISC-V core. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB control registers. It detects load-use hazards and inserts bubbles on hazard or branch flush, and it keeps saturating stall and flush event counters. Decode covers load, store, R-type, branch, I-type ALU, LUI, AUIPC, JAL and JALR.

## Interface
Parameters:
- `REG_AW`, default 5: register-address width.
- `CNT_W`, default 16: event-counter width.
- `EN_JUMP`, default 1: decode JAL/JALR. When 0, both are treated as illegal.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `id_opcode`, in, 7: opcode of the instruction in ID.
- `id_rs1`, `id_rs2`, `id_rd`, in, REG_AW each: register fields of the ID instruction.
- `id_valid`, in, 1: ID holds a real instruction.
- `flush`, in, 1: branch/jump taken, resolved in EX; kill the ID instruction.
- `freeze`, in, 1: external stall; all stage registers hold.
- `hazard_stall`, out, 1: combinational; hold PC and IF/ID.
- `ex_ctrl`, `mem_ctrl`, `wb_ctrl`, out, CTRL_W each: per-stage control bundles.
- `ex_rd`, `mem_rd`, `wb_rd`, out, REG_AW each: destination register per stage.
- `ex_illegal`, out, 1: the EX slot holds an unsupported opcode.
- `stall_cnt`, `flush_cnt`, out, CNT_W each: saturating event counters.

## Operation
- Bundle fields: `alusrc`, `aluop[1:0]`, `branch`, `jump`, `memread`, `memwrite`, `wb_sel[1:0]` (00 = ALU, 01 = memory, 10 = PC+4), `regwrite`. CTRL_W = 10.
- Decode, as (alusrc, aluop, branch, jump, memread, memwrite, wb_sel, regwrite):
  - load 0000011: 1,00,0,0,1,0,01,1
  - store 0100011: 1,00,0,0,0,1,00,0
  - R-type 0110011: 0,10,0,0,0,0,00,1
  - branch 1100011: 0,01,1,0,0,0,00,0
  - I-ALU 0010011: 1,00,0,0,0,0,00,1
  - LUI 0110111 and AUIPC 0010111: 1,11,0,0,0,0,00,1
  - JAL 1101111 and JALR 1100111: 1,00,0,1,0,0,10,1
  - Any other opcode: all-zero bundle, illegal = 1.
- Source usage: rs1 is used by all opcodes except LUI, AUIPC and JAL. rs2 is used only by store, R-type and branch.
- Load-use hazard: `hazard_stall = id_valid & ex_ctrl.memread & ex_rd != 0 & ((use_rs1 & ex_rd == id_rs1) | (use_rs2 & ex_rd == id_rs2)) & !flush & !freeze`.
- ID/EX load priority:
  - `freeze` set: hold all registers.
  - `flush` or `hazard_stall` or `!id_valid`: load a bubble (zero bundle, rd = 0, illegal = 0).
  - Otherwise: load the decoded bundle, `id_rd` and the illegal flag.
- EX/MEM and MEM/WB shift every cycle unless `freeze` is set. `flush` does not kill EX or later stages.
- `stall_cnt` increments on each cycle with `hazard_stall` = 1. `flush_cnt` increments on each unfrozen cycle with `flush` = 1. Both saturate at all-ones.

## Timing
- Reset: all bundles, rd fields, `ex_illegal` and both counters are 0. `hazard_stall` is 0, since it depends on `ex_ctrl`.
- Latency: an ID instruction at cycle n appears on `ex_*` at n+1, `mem_*` at n+2 and `wb_*` at n+3, with no freeze.
- A load-use hazard stalls exactly one cycle. The dependent instruction re-enters ID/EX the next cycle, and `hazard_stall` then drops because EX holds the bubble.
- `flush` and `hazard_stall` in the same cycle: flush wins, `hazard_stall` = 0, only `flush_cnt` increments.
- `freeze` held for k cycles holds everything for k cycles; counters do not change.
- Reset asserted mid-operation clears everything immediately; no pending state survives.

## Structure
- Package `ctrl_pkg` holds:
  - opcode localparams
  - `aluop_t` and `wb_sel_t` enums
  - `ctrl_t` packed struct
  - `CTRL_BUBBLE` constant
- Sub-module `ctrl_decode` is purely combinational. It maps opcode and `EN_JUMP` to bundle, `use_rs1`, `use_rs2` and illegal. `ctrl_pipe` holds the registers, the hazard logic and the counters.

## Test plan
- Reset: assert `rst_n` = 0 mid-stream → all outputs 0 within the same cycle; counters 0.
- R-type `id_opcode` = 0110011, rd = 3 → cycle+1: `ex_ctrl.aluop` = 10, `ex_rd` = 3; cycle+3: `wb_ctrl.regwrite` = 1, `wb_rd` = 3.
- Load-use: lw rd = 5, then add rs1 = 5 → `hazard_stall` = 1 for exactly one cycle, EX bubble, add in EX one cycle later, `stall_cnt` = 1. Repeat with rd = 0 → no stall.
- Flush plus hazard together → `hazard_stall` = 0, EX bubble, `flush_cnt` = 1, `stall_cnt` unchanged.
- `freeze` = 1 for 3 cycles with JAL in EX → `ex/mem/wb` outputs constant and counters constant; after release, JAL reaches WB with `wb_sel` = 10.
- Opcode 1111111, plus JAL with `EN_JUMP` = 0 → `ex_illegal` = 1, zero bundle.
